// File: rtl/mem_io_responder_if.sv
// ---------------------------------------------------------------------------
// mem_io_responder_if : byte-wide memory bus between CPU controller and responder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        io_buffer_full;

    modport master (
        output mem_a, mem_wr, mem_wdata,
        input  mem_rdata, io_buffer_full
    );

    modport slave (
        input  mem_a, mem_wr, mem_wdata,
        output mem_rdata, io_buffer_full
    );
endinterface

`default_nettype wire

// File: rtl/mem_io_responder.sv
// ---------------------------------------------------------------------------
// mem_io_responder : byte RAM plus IO region (paced TX FIFO, RX holding reg, halt)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_io_responder #(
    parameter int RAM_AW      = 17,
    parameter int FIFO_DEPTH  = 8,
    parameter int TX_INTERVAL = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_io_responder_if.slave bus,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  wire logic        tx_ready,
    input  wire logic [7:0]  rx_data,
    input  wire logic        rx_valid,
    output logic             rx_ready,
    output logic             halt,
    output logic             tx_overflow
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PACE_W = (TX_INTERVAL > 1) ? $clog2(TX_INTERVAL) : 1;

    logic [7:0]        ram_q  [0:(1 << RAM_AW) - 1];
    logic [7:0]        fifo_q [0:FIFO_DEPTH - 1];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PACE_W-1:0] pace_q;
    logic [7:0]        rdata_q, rdata_d, rx_byte_q;
    logic              rx_full_q, halt_q, ovf_q;

    logic              w_is_io, w_push_req, w_halt_wr, w_rx_rd;
    logic              w_full, w_buf_full, w_tx_valid, w_pop, w_push, w_rx_cap;
    logic [2:0]        w_off;
    logic [7:0]        w_io_rdata;
    logic              w_unused;

    // Address bits above the decode are don't-care
    assign w_unused   = ^bus.mem_a;

    assign w_is_io    = (bus.mem_a[17:16] == 2'b11);
    assign w_off      = bus.mem_a[2:0];
    assign w_push_req = bus.mem_wr && w_is_io && (w_off == 3'd0);
    assign w_halt_wr  = bus.mem_wr && w_is_io && (w_off == 3'd4);
    assign w_rx_rd    = !bus.mem_wr && w_is_io && (w_off == 3'd0);

    assign w_full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign w_buf_full = (count_q >= CNT_W'(FIFO_DEPTH - 1));
    assign w_tx_valid = (count_q != '0) && (pace_q == '0);
    assign w_pop      = w_tx_valid && tx_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_rx_cap   = rx_valid && !rx_full_q;

    assign bus.mem_rdata      = rdata_q;
    assign bus.io_buffer_full = w_buf_full;
    assign tx_data            = fifo_q[rd_ptr_q];
    assign tx_valid           = w_tx_valid;
    assign rx_ready           = !rx_full_q;
    assign halt               = halt_q;
    assign tx_overflow        = ovf_q;

    always_comb begin
        w_io_rdata = 8'h00;
        if (w_off == 3'd0)
            w_io_rdata = rx_full_q ? rx_byte_q : 8'h00;
        else if (w_off == 3'd4)
            w_io_rdata = {6'b0, rx_full_q, w_buf_full};
        rdata_d = w_is_io ? w_io_rdata : ram_q[bus.mem_a[RAM_AW-1:0]];
    end

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage arrays carry no reset; pointers and flags define their validity
    always_ff @(posedge clk) begin
        if (bus.mem_wr && !w_is_io)
            ram_q[bus.mem_a[RAM_AW-1:0]] <= bus.mem_wdata;
        if (w_push)
            fifo_q[wr_ptr_q] <= bus.mem_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q   <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pace_q    <= '0;
            rx_byte_q <= 8'h00;
            rx_full_q <= 1'b0;
            halt_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (!bus.mem_wr)
                rdata_q <= rdata_d;

            if (w_push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;

            if (w_pop)
                pace_q <= PACE_W'(TX_INTERVAL - 1);
            else if (pace_q != '0)
                pace_q <= pace_q - PACE_W'(1);

            if (w_push_req && !w_push)
                ovf_q <= 1'b1;
            if (w_halt_wr)
                halt_q <= 1'b1;

            // Capture only happens while empty, so it never collides with a clearing read
            if (w_rx_cap) begin
                rx_byte_q <= rx_data;
                rx_full_q <= 1'b1;
            end else if (w_rx_rd) begin
                rx_full_q <= 1'b0;
            end
        end
    end
endmodule

`default_nettype wire

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the byte-wide memory bus driven by the CPU memory controller: `mem_a`, `mem_wr`, write byte in, read byte out, with one-cycle read latency.
- Backs addresses with `a[17:16] != 2'b11` using a byte RAM.
- Decodes `a[17:16] == 2'b11` as the IO region:
  - a TX FIFO that drains to an external sink at a paced rate;
  - a one-entry RX holding register;
  - a halt register.
- Generates `io_buffer_full`, which the controller checks before issuing IO stores.

Parameters:
- `RAM_AW`, 17, RAM address bits; RAM depth is 2^`RAM_AW` bytes and is indexed by `mem_a[RAM_AW-1:0]`.
- `FIFO_DEPTH`, 8, TX FIFO entries; must be a power of 2 and at least 4.
- `TX_INTERVAL`, 4, minimum cycles between consecutive TX pops; must be at least 1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_a`  in  32  byte address from the controller.
- `mem_wr`  in  1  1 = write the byte on `mem_wdata` this cycle; 0 = read.
- `mem_wdata`  in  8  write byte (the controller's `mem_dout`).
- `mem_rdata`  out  8  registered read byte (the controller's `mem_din`).
- `io_buffer_full`  out  1  TX FIFO nearly full; the controller must hold IO stores while this is high.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  head byte offered to the sink.
- `tx_ready`  in  1  sink accepts the byte.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  incoming byte present.
- `rx_ready`  out  1  RX holding register empty.
- `halt`  out  1  sticky; set by a write to `0x30004`.
- `tx_overflow`  out  1  sticky; set when a push is dropped because the FIFO is full.

Behaviour:
- Reset (`rst` = 0, asynchronous):
  - `mem_rdata` = 0; FIFO empty (pointers and count = 0); pace counter = 0.
  - `tx_valid` = 0, `halt` = 0, `tx_overflow` = 0, RX register empty (`rx_ready` = 1).
  - RAM contents are not reset.
  - Reset asserted mid-transfer discards all FIFO and RX contents.
- Address decode: IO when `mem_a[17:16] == 2'b11`, otherwise RAM. Bits above 17 are ignored.
- RAM write: when `mem_wr` = 1 and the address is RAM, `ram[a] <= mem_wdata` on the edge. `mem_rdata` holds its previous value.
- RAM read: when `mem_wr` = 0, `mem_rdata <= ram[a]` on the edge. Data for the address presented in cycle N is valid in cycle N+1.
- Read-after-write to the same address in the next cycle returns the new byte.
- IO write:
  - `a[2:0] == 0` (`0x30000`): push `mem_wdata` to the TX FIFO. If the FIFO is full, drop the byte and set `tx_overflow`.
  - `a[2:0] == 4` (`0x30004`): set `halt`.
  - Other IO offsets: ignored.
- IO read:
  - `0x30000`: `mem_rdata <=` RX byte if the RX register is full, else 0; the RX register is cleared on the same edge.
  - `0x30004`: `mem_rdata <= {6'b0, rx_full, io_buffer_full}`.
  - Other IO offsets: return 0.
- `io_buffer_full` = (`count >= FIFO_DEPTH-1`), decoded from registered `count`.
  - The one-entry margin absorbs the store already in flight when the flag rises, since the controller's decision lags one cycle.
- TX pacing:
  - `tx_valid` = (`count != 0`) && (`pace == 0`); `tx_data` = head byte.
  - Pop on `tx_valid && tx_ready`, and load `pace <= TX_INTERVAL-1`.
  - `pace` decrements by 1 per cycle while nonzero.
  - With `TX_INTERVAL` = 1, back-to-back pops are allowed.
- Simultaneous push and pop: `count` unchanged. The pushed byte is written at the tail and the head advances.
  - Push into a full FIFO in the same cycle as a pop is accepted, because space is freed that edge.
- Pointer wrap: pointers are `log2(FIFO_DEPTH)` bits and wrap naturally; `count` is `log2(FIFO_DEPTH)+1` bits.
- RX:
  - Capture `rx_data` when `rx_valid && rx_ready`; the register becomes full and `rx_ready` = 0.
  - A read of `0x30000` in the same cycle as capture (register empty) returns 0; the new byte remains held.
- Halt:
  - `halt` is sticky until reset and does not block further accesses.
  - Writes while `halt` = 1 behave normally.

Test Plan:
- RAM round trip: write `0xA5` to `0x00010`, then read `0x00010` the next cycle → `mem_rdata` = `0xA5` one cycle after the read address is presented. Read `0x00011` (never written since preload 0) → `0x00`.
- Read latency: sweep addresses `0`..`3` holding preloaded `11`,`22`,`33`,`44` on consecutive cycles → `mem_rdata` shows `11`,`22`,`33`,`44` each lagging one cycle.
- FIFO fill, `tx_ready` = 0: push 7 bytes to `0x30000` → `io_buffer_full` rises after the 7th. The 8th push is accepted; the 9th is dropped and `tx_overflow` = 1.
- Paced drain, `TX_INTERVAL` = 4, `tx_ready` = 1, pushes `01`..`03` → `tx_valid` pulses with `01`,`02`,`03` exactly 4 cycles apart; `io_buffer_full` falls when count ≤ 6.
- RX and status: drive `rx_data` = `0x5C` with `rx_valid` → `rx_ready` drops. Read `0x30004` → `0x02`. Read `0x30000` → `0x5C`. Read `0x30000` again → `0x00`, and `rx_ready` = 1.
- Halt and async reset: write to `0x30004` → `halt` = 1. Assert `rst` = 0 mid-drain with count = 3 → immediately count = 0, `tx_valid` = 0, `halt` = 0, `mem_rdata` = 0.
